display_scan_7seg: RTL

Downstream consumer of the current/frequency BCD data selector. Takes the four BCD digits r0 (units) to r3 (thousands) and the current/frequency mode flag. Drives a 4-digit common-anode 7-segment display by time-multiplexing the digits, with leading-zero blanking, frame-coherent snapshots and a mode indicator on the decimal point.

---
 rtl/display_pkg.sv | 32 +++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/display_scan_7seg.sv | 121 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 4-digit common-anode scanner: active-low segment
// patterns {g,f,e,d,c,b,a} and anode helpers.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_DASH   = 7'b0111111;
    localparam logic [3:0] ANODES_OFF = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    typedef logic [3:0] bcd_t;

    // Active-low one-hot anode pattern for scan position idx (an[0] = units).
    function automatic logic [3:0] anode_select_n(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot      = 4'b0000;
        onehot[idx] = 1'b1;
        return ~onehot;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_7seg.sv
// Time-multiplexed 4-digit 7-segment driver with frame-coherent snapshots,
// leading-zero blanking, a one-cycle ghost guard per slot and a mode dp.
module display_scan_7seg
    import display_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] r0,
    input  logic [3:0] r1,
    input  logic [3:0] r2,
    input  logic [3:0] r3,
    input  logic       mode,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    bcd_t             r_snap [NUM_DIGITS];
    logic             r_snap_mode;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    bcd_t             w_in [NUM_DIGITS];
    logic             w_tick;
    logic             w_frame_end;
    logic [NUM_DIGITS-1:0] w_zero;
    logic [NUM_DIGITS-1:0] w_blank;
    bcd_t             w_digit;
    logic [6:0]       w_seg_dec;
    logic [6:0]       w_seg_sel;

    assign w_in[0] = r0;
    assign w_in[1] = r1;
    assign w_in[2] = r2;
    assign w_in[3] = r3;

    assign w_tick      = (r_cnt == CNT_W'(PRESCALE - 1));
    assign w_frame_end = w_tick && (r_idx == 2'd3);

    // Prescaler and scan index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // All digits and mode are captured on the same edge so a frame never mixes values.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_snap
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_snap[gi] <= '0;
                end else if (w_frame_end) begin
                    r_snap[gi] <= w_in[gi];
                end
            end
            assign w_zero[gi] = (r_snap[gi] == 4'd0);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_mode <= 1'b0;
        end else if (w_frame_end) begin
            r_snap_mode <= mode;
        end
    end

    // A digit blanks only if it and every digit to its left are zero; codes
    // 10..15 compare non-zero, so they stop blanking naturally.
    assign w_blank[NUM_DIGITS-1] = w_zero[NUM_DIGITS-1];
    generate
        for (genvar gi = 1; gi < NUM_DIGITS - 1; gi++) begin : g_blank
            assign w_blank[gi] = w_zero[gi] && w_blank[gi+1];
        end
    endgenerate
    assign w_blank[0] = 1'b0;

    assign w_digit = r_snap[r_idx];

    bcd_to_7seg u_dec (
        .i_code (w_digit),
        .o_seg  (w_seg_dec)
    );

    assign w_seg_sel = w_blank[r_idx] ? SEG_BLANK : w_seg_dec;

    // Registered outputs; the tick cycle turns all anodes off to hide ghosting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= ANODES_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_tick) begin
            r_an  <= ANODES_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= anode_select_n(r_idx);
            r_seg <= w_seg_sel;
            r_dp  <= ~((r_idx == 2'd0) && r_snap_mode);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
